dmem_port_arbiter: RTL
======================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single vector data-memory port between the pipeline's memory/writeback access and an
//  external host/loader port (image/vector preload, result readback). Sits in front of data_memory:
//  pipeline and host request in, one memory command out, read data returned with validity flags.
//  Pipeline has priority. Host gets bounded bursts. A starvation counter guarantees host progress.
// PARAMETERS
//  vecSize       4  lanes per vector word
//  registerSize  8  bits per lane; also address width
//  MAX_BURST     4  max consecutive host beats before the host is forced to yield (>=1)
//  STARVE_LIMIT  8  consecutive cycles a waiting host may be denied before a forced grant (>=1)
// PORTS
//  clk          in   1                      clock, rising edge
//  reset        in   1                      synchronous, active-low
//  pipe_req     in   1                      pipeline requests memory this cycle
//  pipe_we      in   1                      1=store, 0=load
//  pipe_addr    in   registerSize           pipeline address
//  pipe_wdata   in   vecSize*registerSize   pipeline store data
//  pipe_stall   out  1                      pipe_req not served this cycle; pipeline holds
//  pipe_rvalid  out  1                      pipeline load data valid on pipe_rdata
//  pipe_rdata   out  vecSize*registerSize   load data to writeback mux
//  host_req     in   1                      host beat request; held with addr/we/wdata until host_gnt
//  host_we      in   1                      1=write, 0=read
//  host_addr    in   registerSize           host address
//  host_wdata   in   vecSize*registerSize   host write data
//  host_gnt     out  1                      host beat accepted this cycle
//  host_rvalid  out  1                      host read data valid on host_rdata
//  host_rdata   out  vecSize*registerSize   host read data
//  mem_we       out  1                      to data_memory write_enable
//  mem_addr     out  registerSize           to data_memory DataAdr
//  mem_wdata    out  vecSize*registerSize   to data_memory toWrite_data
//  mem_rdata    in   vecSize*registerSize   from data_memory; valid 1 cycle after read address
//  owner_host   out  1                      FSM in S_HOST (debug)
// BEHAVIOUR
//  States: S_PIPE (default), S_HOST. Regs: beat_cnt, starve_cnt, rd_tag_pipe, rd_tag_host.
//  Reset (reset==0 at edge): state=S_PIPE, beat_cnt=0, starve_cnt=0, rvalids=0.
//   While reset==0, all grants are forced 0, so mem_we=0, host_gnt=0, pipe_stall=0.
//  Grant is combinational from state+requests. At most one grant per cycle. Ungranted: mem_we=0.
//  Granted side drives mem_we/mem_addr/mem_wdata. Idle: mem_addr=0, mem_wdata=0.
//  S_PIPE:
//   - If host_req and starve_cnt==STARVE_LIMIT, grant host. Stall pipe if pipe_req.
//     Go to S_HOST with beat_cnt=1 and starve_cnt=0.
//   - Else if pipe_req, grant pipe. starve_cnt+=1 if host_req, else cleared.
//   - Else if host_req, grant host. Go to S_HOST with beat_cnt=1 and starve_cnt=0.
//   - Else idle; starve_cnt=0.
//  S_HOST:
//   - If host_req and beat_cnt<MAX_BURST, grant host and increment beat_cnt.
//     pipe_stall=pipe_req. Stay in S_HOST.
//   - Otherwise (host dropped or burst exhausted), return to S_PIPE and clear beat_cnt.
//     In that same cycle, pipe_req is granted. If pipe_req is idle and host_req is set,
//     host is granted and a new burst starts.
//   - With MAX_BURST=1, S_HOST is left every cycle.
//  pipe_stall = pipe_req & ~pipe_grant, exactly.
//  Read return: a granted read (we=0) sets the matching rvalid for exactly the next cycle.
//   host_rdata=pipe_rdata=mem_rdata (passthrough). Write beats never raise rvalid.
//  Back-to-back reads give one rvalid per cycle in order. The two rvalids are never both 1.
//  Host contract: host_req/addr/we/wdata stable while host_gnt=0. May change the cycle after a grant.
//  Simultaneous pipe_req & host_req in S_PIPE below STARVE_LIMIT: pipe wins, host_gnt=0.
//  Reset mid-burst or with a read outstanding: in-flight rvalid is dropped (0 next cycle).
//   No memory write issues during reset.
//  Counters saturate: starve_cnt never exceeds STARVE_LIMIT; beat_cnt never exceeds MAX_BURST.
// TESTING
//  1 Reset: reset=0 3 cycles with pipe_req=host_req=1, we=1 -> mem_we=0, host_gnt=0, rvalids=0.
//  2 Pipe only: store addr 0x10 data {4,3,2,1}, then load 0x10 -> mem_we=1 at beat 1.
//    pipe_rvalid=1 one cycle after load with pipe_rdata={4,3,2,1}; pipe_stall=0 throughout.
//  3 Host burst: host_req held 6 writes 0x20..0x25, no pipe traffic, MAX_BURST=4.
//    -> 4 grants in S_HOST, then a return to S_PIPE immediately re-granting host.
//    All 6 writes land; host_gnt never drops.
//  4 Preemption: pipe_req rises during host beat 2 -> pipe_stall=1 until beat_cnt hits 4.
//    Pipe is granted on the next cycle; host_gnt=0 that cycle.
//  5 Starvation: pipe_req=1 continuously, host_req=1.
//    -> host_gnt=1 on cycle STARVE_LIMIT+1 (9th cycle) with pipe_stall=1.
//  6 Reset mid-read: host read granted, reset=0 next cycle -> host_rvalid=0.
//    Post-reset state=S_PIPE, owner_host=0.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single vector data-memory port between the pipeline and the host/loader port.
// The pipeline has priority; the host gets bounded bursts and a guaranteed grant after a starvation window.
module dmem_port_arbiter #(
  parameter int unsigned vecSize      = 4,
  parameter int unsigned registerSize = 8,
  parameter int unsigned MAX_BURST    = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              pipe_req,
  input  logic                              pipe_we,
  input  logic [registerSize-1:0]           pipe_addr,
  input  logic [vecSize*registerSize-1:0]   pipe_wdata,
  output logic                              pipe_stall,
  output logic                              pipe_rvalid,
  output logic [vecSize*registerSize-1:0]   pipe_rdata,
  input  logic                              host_req,
  input  logic                              host_we,
  input  logic [registerSize-1:0]           host_addr,
  input  logic [vecSize*registerSize-1:0]   host_wdata,
  output logic                              host_gnt,
  output logic                              host_rvalid,
  output logic [vecSize*registerSize-1:0]   host_rdata,
  output logic                              mem_we,
  output logic [registerSize-1:0]           mem_addr,
  output logic [vecSize*registerSize-1:0]   mem_wdata,
  input  logic [vecSize*registerSize-1:0]   mem_rdata,
  output logic                              owner_host
);

  localparam int unsigned DataW   = vecSize * registerSize;
  localparam int unsigned BeatW   = $clog2(MAX_BURST + 1);
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  localparam logic [BeatW-1:0]   BeatMax   = BeatW'(MAX_BURST);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  typedef enum logic {
    S_PIPE = 1'b0,
    S_HOST = 1'b1
  } arbStateT;

  arbStateT            state;
  logic [BeatW-1:0]    beatCnt;
  logic [StarveW-1:0]  starveCnt;
  logic                rdTagPipe;
  logic                rdTagHost;
  logic                pipeGnt;
  logic                hostGnt;
  logic                burstContinue;

  assign burstContinue = (state == S_HOST) && host_req && (beatCnt < BeatMax);

  // Grant decode: at most one side per cycle, nothing granted while reset is asserted.
  always_comb begin
    pipeGnt = 1'b0;
    hostGnt = 1'b0;
    if (reset) begin
      unique case (state)
        S_PIPE: begin
          if (host_req && (starveCnt == StarveMax)) begin
            hostGnt = 1'b1;
          end else if (pipe_req) begin
            pipeGnt = 1'b1;
          end else if (host_req) begin
            hostGnt = 1'b1;
          end
        end
        S_HOST: begin
          if (burstContinue) begin
            hostGnt = 1'b1;
          end else if (pipe_req) begin
            pipeGnt = 1'b1;
          end else if (host_req) begin
            hostGnt = 1'b1;
          end
        end
        default: begin
          pipeGnt = 1'b0;
          hostGnt = 1'b0;
        end
      endcase
    end
  end

  // Memory command mux; an idle port presents zeros.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (pipeGnt) begin
      mem_we    = pipe_we;
      mem_addr  = pipe_addr;
      mem_wdata = pipe_wdata;
    end else if (hostGnt) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  assign pipe_stall = reset & pipe_req & ~pipeGnt;
  assign host_gnt   = hostGnt;

  // Read data is a straight passthrough; only the validity flags are tracked here.
  assign pipe_rdata  = DataW'(mem_rdata);
  assign host_rdata  = DataW'(mem_rdata);
  assign pipe_rvalid = rdTagPipe;
  assign host_rvalid = rdTagHost;
  assign owner_host  = (state == S_HOST);

  // Ownership state, burst/starvation counters and read tags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_PIPE;
      beatCnt   <= '0;
      starveCnt <= '0;
      rdTagPipe <= 1'b0;
      rdTagHost <= 1'b0;
    end else begin
      rdTagPipe <= pipeGnt & ~pipe_we;
      rdTagHost <= hostGnt & ~host_we;
      if (hostGnt) begin
        state     <= S_HOST;
        starveCnt <= '0;
        beatCnt   <= burstContinue ? beatCnt + BeatW'(1) : BeatW'(1);
      end else begin
        state   <= S_PIPE;
        beatCnt <= '0;
        if (pipeGnt && host_req) begin
          // Host is waiting behind the pipeline; count the denial, saturating.
          starveCnt <= (starveCnt < StarveMax) ? starveCnt + StarveW'(1) : starveCnt;
        end else begin
          starveCnt <= '0;
        end
      end
    end
  end

endmodule
